// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) transmit path.
//
// Codeword layout (bit 6..0 = positions 7..1): i3, i2, i1, c2, i0, c1, c0.
// The parity bits sit at the power-of-two positions 1, 2 and 4, so the
// receiver's syndrome points directly at the position of a single bad bit.
package hamming_pkg;

   typedef logic [6:0] codeword_t;
   typedef logic [3:0] data_t;

   localparam int CW_BITS = 7;

   // 1-based codeword positions
   localparam int POS_C0 = 1;
   localparam int POS_C1 = 2;
   localparam int POS_I0 = 3;
   localparam int POS_C2 = 4;
   localparam int POS_I1 = 5;
   localparam int POS_I2 = 6;
   localparam int POS_I3 = 7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_t;

   // Each parity bit covers the positions whose index has that parity
   // bit's weight set (c0: 3,5,7 / c1: 3,6,7 / c2: 5,6,7).
   function automatic codeword_t hamming_encode(input data_t d);
      codeword_t cw;
      cw             = '0;
      cw[POS_I0 - 1] = d[0];
      cw[POS_I1 - 1] = d[1];
      cw[POS_I2 - 1] = d[2];
      cw[POS_I3 - 1] = d[3];
      cw[POS_C0 - 1] = d[0] ^ d[1] ^ d[3];
      cw[POS_C1 - 1] = d[0] ^ d[2] ^ d[3];
      cw[POS_C2 - 1] = d[1] ^ d[2] ^ d[3];
      return cw;
   endfunction

endpackage

// File: rtl/hamming_tx_serializer_enc.sv
// Combinational Hamming(7,4) encoder with optional single-bit error injection.
// Reusable on its own as a golden reference.
//
// Ports:
//   data_i     - data word i3..i0
//   err_pos_i  - position 1..7 to invert after encoding; 0 = no injection
//   codeword_o - encoded (and possibly corrupted) codeword
module hamming_enc7_4
   import hamming_pkg::*;
(
   input  data_t      data_i,
   input  logic [2:0] err_pos_i,
   output codeword_t  codeword_o
);

   codeword_t flip_mask;

   // NOTE: every variable assigned in an always_comb gets a default first,
   // so no path can leave it unassigned and infer a latch.
   always_comb begin
      flip_mask = '0;
      if (err_pos_i != 3'd0) begin
         flip_mask = codeword_t'(1) << (err_pos_i - 3'd1);
      end
   end

   assign codeword_o = hamming_encode(data_i) ^ flip_mask;

endmodule

// File: rtl/hamming_tx_serializer.sv
// Transmit end of the Hamming(7,4) link: accepts a 4-bit word over a
// valid/ready handshake, encodes it (with optional error injection) and
// shifts the frame out as start bit, 7 codeword bits MSB first, stop bit.
// Every bit lasts CLKS_PER_BIT cycles, so a frame is 9*CLKS_PER_BIT cycles.
//
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   data_i      - data word i3..i0, sampled at accept
//   err_pos_i   - error position 1..7 to flip, 0 = none, sampled at accept
//   valid_i     - input word valid; accept when valid_i && ready_o
//   ready_o     - block is idle and can accept a word
//   codeword_o  - codeword of the current/last frame (after injection)
//   serial_o    - serial line, IDLE_LEVEL when idle and during stop
//   busy_o      - frame in progress
//   done_o      - one-cycle pulse in the final cycle of the stop bit
module hamming_tx_serializer
   import hamming_pkg::*;
#(
   parameter int   CLKS_PER_BIT = 4,
   parameter logic IDLE_LEVEL   = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] data_i,
   input  logic [2:0] err_pos_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic [6:0] codeword_o,
   output logic       serial_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        BIT_LAST  = 3'(CW_BITS - 1);

   tx_state_t         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   codeword_t         shift_q, shift_d;
   codeword_t         codeword_q, codeword_d;
   logic              serial_q, serial_d;

   codeword_t enc_cw;
   logic      baud_last;
   logic      accept;

   hamming_enc7_4 u_enc (
      .data_i     (data_i),
      .err_pos_i  (err_pos_i),
      .codeword_o (enc_cw)
   );

   assign baud_last = (baud_q == BAUD_LAST);
   assign accept    = (state_q == ST_IDLE) && valid_i;

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      codeword_d = codeword_q;

      // Outside IDLE the baud counter free-runs and wraps on each bit boundary.
      if (state_q != ST_IDLE) begin
         baud_d = baud_last ? '0 : baud_q + 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               shift_d    = enc_cw;
               codeword_d = enc_cw;
               baud_d     = '0;
               bit_d      = '0;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            if (baud_last) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (baud_last) begin
               shift_d = {shift_q[5:0], 1'b0};
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
                  state_d = ST_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         ST_STOP: begin
            if (baud_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // The line is registered from the next state so it changes cleanly on
      // the clock edge; the first DATA cycle shows shift_d[6] = position 7.
      unique case (state_d)
         ST_START: serial_d = ~IDLE_LEVEL;
         ST_DATA:  serial_d = shift_d[6];
         default:  serial_d = IDLE_LEVEL;
      endcase
   end

   // NOTE: state elements use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         codeword_q <= '0;
         serial_q   <= IDLE_LEVEL;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         codeword_q <= codeword_d;
         serial_q   <= serial_d;
      end
   end

   assign ready_o    = (state_q == ST_IDLE);
   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = (state_q == ST_STOP) && baud_last;
   assign codeword_o = codeword_q;
   assign serial_o   = serial_q;

endmodule

// File: doc/hamming_tx_serializer.md
Name: hamming_tx_serializer

Overview:
Transmit end of the Hamming(7,4) link. Accepts a 4-bit data word via a valid/ready handshake and encodes it to a 7-bit codeword in order i3,i2,i1,c2,i0,c1,c0 (bit 6..0 = positions 7..1). It can optionally flip one position for error-injection demos. It then shifts the frame out serially to the existing decoder/corrector side.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit (legal range >= 1)
IDLE_LEVEL, 1'b1, serial line level in idle and stop

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
data_i  input  4  data word i3..i0
err_pos_i  input  3  error position 1..7 is flipped before send; 0 means no injection
valid_i  input  1  data_i/err_pos_i valid
ready_o  output  1  block can accept a word
codeword_o  output  7  registered codeword of the current/last frame, after injection
serial_o  output  1  serial line
busy_o  output  1  frame in progress
done_o  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; serial_o=IDLE_LEVEL; ready_o=1; busy_o=0; done_o=0; codeword_o=0; counters=0.
  - Reset mid-frame aborts immediately; the line returns to idle level without waiting for a clock.
- Parity (pre-injection):
  - c0 = i0^i1^i3 (positions 3,5,7)
  - c1 = i0^i2^i3 (positions 3,6,7)
  - c2 = i1^i2^i3 (positions 5,6,7)
- Injection: if err_pos_i = p, with p in 1..7, bit (p-1) of the codeword is inverted. err_pos_i = 0 leaves it unchanged.
- Handshake:
  - Accept happens on the rising edge where valid_i && ready_o.
  - data_i and err_pos_i are sampled only at accept. Later changes have no effect.
  - valid_i while busy is ignored; no queuing.
  - ready_o = (state==IDLE).
- FSM states IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: serial_o=IDLE_LEVEL. On accept, load shift register and codeword_o, then go to START.
  - START: serial_o = ~IDLE_LEVEL for CLKS_PER_BIT cycles.
  - DATA: 7 bits, MSB first (position 7 first). Each bit is held CLKS_PER_BIT cycles. A 3-bit bit counter is used. After the 7th bit, go to STOP.
  - STOP: serial_o=IDLE_LEVEL for CLKS_PER_BIT cycles. In its final cycle done_o=1 and the next state is IDLE. ready_o returns high the cycle after done_o.
- Timing:
  - serial_o drives the start level in the first cycle after the accept edge.
  - Frame length is exactly 9*CLKS_PER_BIT cycles; back-to-back frames are spaced by at least 1 idle cycle.
- busy_o = (state != IDLE).
- codeword_o holds its value after the frame until the next accept.
- Baud counter width is $clog2(CLKS_PER_BIT) bits, minimum 1. It wraps to 0 on each bit boundary. CLKS_PER_BIT=1 must work, giving a bit change every cycle.
- Accept while done_o is asserted is impossible (ready_o is low). The simultaneous valid_i and done_o case needs no special handling.

Decomposition:
- Package hamming_pkg holds:
  - typedef codeword_t (logic [6:0]) and data_t (logic [3:0])
  - position constants POS_C0=1, POS_C1=2, POS_I0=3, POS_C2=4, POS_I1=5, POS_I2=6, POS_I3=7
  - function hamming_encode(data_t) returning codeword_t
  - tx state enum
- One combinational sub-module, hamming_enc7_4 (data_t in, err_pos in, codeword_t out), containing the encode and injection logic. It is reusable by benches as a golden model.

Test Plan:
- data_i=4'b1101, err_pos_i=0, CLKS_PER_BIT=4 -> codeword_o=7'b1100110. serial_o shows 0, then 1,1,0,0,1,1,0, then 1, each held 4 cycles. done_o pulses in cycle 36 after accept.
- data_i=4'b1101, err_pos_i=5 -> codeword_o=7'b1110110. The decoder side reports syndrome 3'b101 and corrected 1101.
- data_i=4'b0110, err_pos_i=6 -> 7'b0010011. data_i=4'b1010, err_pos_i=7 -> 7'b0010010. data_i=4'b1010, err_pos_i=2 -> 7'b1010000.
- Second valid_i pulse with data_i=4'b1111 asserted mid-frame -> ignored; codeword_o and serial bits unchanged; ready_o stays 0 until after done_o.
- rst_n pulsed low during DATA bit 3 -> serial_o=1 and ready_o=1 asynchronously; the next accept of 4'b0000 sends 7'b0000000 with a full start/stop frame.
- CLKS_PER_BIT=1, back-to-back valid_i held high with 4'b1010 -> frames of 9 cycles separated by exactly one idle cycle; done_o is one cycle wide each time.
